counter_bank: RTL and testbench
===============================

Name: counter_bank

Overview:
- Parametrised bank of NUM_CH independent up/down counters, each WIDTH bits wide.
- Each channel supports:
  - synchronous load;
  - per-channel wrap or saturate mode;
  - overflow and underflow event pulses;
  - a compare-match flag.
- Serves as the general-purpose counting element for timers, performance counters and event tallies in the SoC. It supersedes the single-channel increment-only counter.

Parameters:
- WIDTH, 32, bit width of each channel counter (≥2).
- NUM_CH, 4, number of independent channels (≥1).
- PRESET, 0, reset value loaded into every channel (truncated to WIDTH).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous reset, active-high.
- inc  input  NUM_CH  per-channel increment request.
- dec  input  NUM_CH  per-channel decrement request.
- load  input  NUM_CH  per-channel synchronous load strobe.
- load_val  input  NUM_CH*WIDTH  load values; channel i uses bits [i*WIDTH +: WIDTH].
- sat_mode  input  NUM_CH  per-channel mode: 1 = saturate, 0 = wrap.
- cmp_val  input  NUM_CH*WIDTH  per-channel compare value, packed like load_val.
- q  output  NUM_CH*WIDTH  current counter values, packed like load_val.
- ovf  output  NUM_CH  registered one-cycle overflow event pulse.
- udf  output  NUM_CH  registered one-cycle underflow event pulse.
- match  output  NUM_CH  combinational: q channel i == cmp_val channel i.

Behaviour:
- Interface: one clock (clk). Reset is synchronous and active-high (reset). Polarity and synchronicity are fixed.
- Reset, sampled at rising clk:
  - every channel q ← PRESET;
  - ovf ← 0, udf ← 0.
  - match reflects PRESET vs cmp_val immediately after reset.
- Channels are fully independent; no cross-channel interaction.
- Per-channel priority each cycle: reset > load > (inc xor dec) > hold.
- Load:
  - q ← load_val.
  - ovf and udf are 0 next cycle, regardless of inc/dec in the same cycle.
- inc=1, dec=0:
  - q < MAX (2^WIDTH−1): q ← q+1, no flag.
  - q == MAX, wrap mode: q ← 0, ovf pulses.
  - q == MAX, saturate mode: q stays MAX, ovf pulses (an attempted overflow is still reported).
- dec=1, inc=0:
  - q > 0: q ← q−1.
  - q == 0, wrap mode: q ← MAX, udf pulses.
  - q == 0, saturate mode: q stays 0, udf pulses.
- inc=1 and dec=1 together: q holds, no flag (net zero).
- Flag timing:
  - ovf/udf are registered, so they are high for exactly the one cycle following the clock edge where the event was evaluated, aligned with the updated q.
  - They deassert the next cycle unless a new event occurs; back-to-back events in saturate mode give a continuous high.
- sat_mode is sampled on the same edge as inc/dec; changing it mid-count has no other side effect.
- Arithmetic is unsigned modulo 2^WIDTH. No intermediate value wider than WIDTH+1 is needed.
- match is purely combinational from registered q and cmp_val; it has no latency relative to q.
- Reset asserted mid-operation overrides load/inc/dec in that cycle. Pending flags clear at the same edge.
- No X propagation: all outputs are defined from the first post-reset cycle.

Test Plan (WIDTH=4, NUM_CH=2, PRESET=3 unless stated):
- Reset, then idle 2 cycles → q = {3,3}, ovf = udf = 00; with cmp_val ch0=3, ch1=5, match = 01 (ch0 set).
- Ch0 wrap mode: load 14, then inc for 3 cycles → q0 = 15, 0, 1. ovf[0] high only in the cycle q0 = 0. Ch1 remains 3 throughout.
- Ch1 saturate mode: load 1, then dec for 3 cycles → q1 = 0, 0, 0. udf[1] low, high, high (two attempted underflows).
- Ch0 at 7: assert inc, dec and load (load_val=9) together → q0 = 9, no flags. Next cycle inc and dec only → q0 stays 9, no flags.
- Ch0 counting with inc held, q0 = 10: assert reset for one cycle → q0 = 3 and ovf/udf = 00 at that edge. Counting resumes 4, 5 after reset drops.
- Ch0 wrap mode at 0: dec → q0 = 15 with udf[0] pulsed. Then inc → q0 = 0 with ovf[0] pulsed and udf[0] cleared.

Source files
------------

// File: rtl/counter_bank.sv
// rtl/counter_bank.sv - bank of independent up/down counters with load, wrap/saturate, ovf/udf pulses and compare match
//
// Ports:
//   clk       system clock, all state updates on the rising edge
//   reset     synchronous reset, active-high
//   inc       per-channel increment request
//   dec       per-channel decrement request
//   load      per-channel synchronous load strobe
//   load_val  per-channel load value, channel i in [i*WIDTH +: WIDTH]
//   sat_mode  per-channel mode: 1 = saturate, 0 = wrap
//   cmp_val   per-channel compare value, packed like load_val
//   q         per-channel counter value, packed like load_val
//   ovf       registered one-cycle overflow pulse
//   udf       registered one-cycle underflow pulse
//   match     combinational q == cmp_val per channel
module counter_bank #(
    parameter int                WIDTH  = 32,
    parameter int                NUM_CH = 4,
    parameter logic [WIDTH-1:0]  PRESET = '0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_CH-1:0]        inc,
    input  logic [NUM_CH-1:0]        dec,
    input  logic [NUM_CH-1:0]        load,
    input  logic [NUM_CH*WIDTH-1:0]  load_val,
    input  logic [NUM_CH-1:0]        sat_mode,
    input  logic [NUM_CH*WIDTH-1:0]  cmp_val,
    output logic [NUM_CH*WIDTH-1:0]  q,
    output logic [NUM_CH-1:0]        ovf,
    output logic [NUM_CH-1:0]        udf,
    output logic [NUM_CH-1:0]        match
);

    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
        logic [WIDTH-1:0] cnt;
        logic             ovf_r;
        logic             udf_r;
        logic             at_max;
        logic             at_zero;

        assign at_max  = &cnt;
        assign at_zero = ~|cnt;

        always_ff @(posedge clk) begin
            if (reset) begin
                cnt   <= PRESET;
                ovf_r <= 1'b0;
                udf_r <= 1'b0;
            end else begin
                // Flags are single-cycle unless the event repeats.
                ovf_r <= 1'b0;
                udf_r <= 1'b0;
                if (load[ch]) begin
                    cnt <= load_val[ch*WIDTH +: WIDTH];
                end else if (inc[ch] && !dec[ch]) begin
                    if (at_max) begin
                        // Attempted overflow is reported even when saturating.
                        ovf_r <= 1'b1;
                        if (!sat_mode[ch]) cnt <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end else if (dec[ch] && !inc[ch]) begin
                    if (at_zero) begin
                        udf_r <= 1'b1;
                        if (!sat_mode[ch]) cnt <= '1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
            end
        end

        assign q[ch*WIDTH +: WIDTH] = cnt;
        assign ovf[ch]              = ovf_r;
        assign udf[ch]              = udf_r;
        assign match[ch]            = (cnt == cmp_val[ch*WIDTH +: WIDTH]);
    end

endmodule

// File: tb/tb_counter_bank.sv
// tb/tb_counter_bank.sv - scoreboard bench for counter_bank with directed plan and random stimulus
module tb_counter_bank;

    localparam int W = 4;
    localparam int N = 2;

    logic           clk = 1'b0;
    logic           reset;
    logic [N-1:0]   inc, dec, load, sat_mode;
    logic [N*W-1:0] load_val, cmp_val;
    logic [N*W-1:0] q;
    logic [N-1:0]   ovf, udf, match;

    always #5 clk = ~clk;

    counter_bank #(.WIDTH(W), .NUM_CH(N), .PRESET(4'd3)) dut (
        .clk      (clk),
        .reset    (reset),
        .inc      (inc),
        .dec      (dec),
        .load     (load),
        .load_val (load_val),
        .sat_mode (sat_mode),
        .cmp_val  (cmp_val),
        .q        (q),
        .ovf      (ovf),
        .udf      (udf),
        .match    (match)
    );

    typedef struct {
        logic [N*W-1:0] q;
        logic [N-1:0]   ovf;
        logic [N-1:0]   udf;
        logic [N-1:0]   match;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   mq[N];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: counter values held as plain integers, limits applied arithmetically.
    task automatic drive(input bit rst, input logic [N-1:0] i, input logic [N-1:0] d,
                         input logic [N-1:0] l, input logic [N*W-1:0] lv,
                         input logic [N-1:0] sat, input logic [N*W-1:0] cv);
        exp_t e;
        @(negedge clk);
        reset = rst; inc = i; dec = d; load = l; load_val = lv; sat_mode = sat; cmp_val = cv;
        for (int c = 0; c < N; c++) begin
            int nq;
            bit o, u;
            logic [W-1:0] lvc, cvc, nqv;
            lvc = lv[c*W +: W];
            cvc = cv[c*W +: W];
            nq = mq[c]; o = 0; u = 0;
            if (rst) nq = 3;
            else if (l[c]) nq = int'(lvc);
            else if (i[c] && !d[c]) begin
                nq = mq[c] + 1;
                if (nq > 15) begin o = 1; nq = sat[c] ? 15 : nq - 16; end
            end else if (d[c] && !i[c]) begin
                nq = mq[c] - 1;
                if (nq < 0) begin u = 1; nq = sat[c] ? 0 : nq + 16; end
            end
            mq[c] = nq;
            nqv = nq[W-1:0];
            e.q[c*W +: W] = nqv;
            e.ovf[c]      = o;
            e.udf[c]      = u;
            e.match[c]    = (nqv == cvc);
        end
        sb.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("q", 32'(q), 32'(e.q));
                chk("ovf", 32'(ovf), 32'(e.ovf));
                chk("udf", 32'(udf), 32'(e.udf));
                chk("match", 32'(match), 32'(e.match));
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL timeout checks=%0d", checks);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "timeout");
    end

    initial begin : stim
        logic [N*W-1:0] cv;
        reset = 1'b1; inc = '0; dec = '0; load = '0; load_val = '0; sat_mode = '0; cmp_val = '0;
        cv = 8'h53;

        drive(1, 2'b00, 2'b00, 2'b00, 8'h00, 2'b10, cv);
        drive(0, 2'b00, 2'b00, 2'b00, 8'h00, 2'b10, cv);
        drive(0, 2'b00, 2'b00, 2'b00, 8'h00, 2'b10, cv);
        @(posedge clk); #2;
        chk("reset_q", 32'(q), 32'h33);
        chk("reset_match", 32'(match), 32'h1);
        chk("reset_flags", 32'({ovf, udf}), 32'h0);

        // ch0 wrap: 14 -> 15, 0, 1
        drive(0, 2'b00, 2'b00, 2'b01, 8'h0E, 2'b10, cv);
        repeat (3) drive(0, 2'b01, 2'b00, 2'b00, 8'h00, 2'b10, cv);
        // ch1 saturate underflow: 1 -> 0, 0, 0
        drive(0, 2'b00, 2'b00, 2'b10, 8'h10, 2'b10, cv);
        repeat (3) drive(0, 2'b00, 2'b10, 2'b00, 8'h00, 2'b10, cv);
        @(posedge clk); #2;
        chk("sat_udf_q1", 32'(q[7:4]), 32'h0);
        chk("sat_udf_flag", 32'(udf), 32'h2);
        // load wins over inc/dec; inc+dec holds
        drive(0, 2'b00, 2'b00, 2'b01, 8'h07, 2'b10, cv);
        drive(0, 2'b01, 2'b01, 2'b01, 8'h09, 2'b10, cv);
        drive(0, 2'b01, 2'b01, 2'b00, 8'h00, 2'b10, cv);
        // reset mid-count
        drive(0, 2'b00, 2'b00, 2'b01, 8'h08, 2'b10, cv);
        repeat (2) drive(0, 2'b01, 2'b00, 2'b00, 8'h00, 2'b10, cv);
        drive(1, 2'b01, 2'b00, 2'b00, 8'h00, 2'b10, cv);
        repeat (2) drive(0, 2'b01, 2'b00, 2'b00, 8'h00, 2'b10, cv);
        // ch0 wrap at 0: dec -> 15 udf, inc -> 0 ovf
        drive(0, 2'b00, 2'b00, 2'b01, 8'h00, 2'b10, cv);
        drive(0, 2'b00, 2'b01, 2'b00, 8'h00, 2'b10, cv);
        drive(0, 2'b01, 2'b00, 2'b00, 8'h00, 2'b10, cv);
        @(posedge clk); #2;
        chk("wrap_inc_q0", 32'(q[3:0]), 32'h0);
        chk("wrap_inc_ovf", 32'(ovf), 32'h1);
        chk("wrap_inc_udf", 32'(udf), 32'h0);

        for (int k = 0; k < 400; k++) begin
            logic [N-1:0]   ri, rd, rl, rs;
            logic [N*W-1:0] rlv, rcv;
            bit             rr;
            ri  = N'($urandom);
            rd  = N'($urandom);
            rl  = {($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0)};
            rs  = N'($urandom);
            rlv = (N*W)'($urandom);
            rcv = (N*W)'($urandom);
            rr  = ($urandom_range(0, 31) == 0);
            drive(rr, ri, rd, rl, rlv, rs, rcv);
        end

        repeat (3) @(posedge clk);
        #3;
        chk("sb_drain", 32'(sb.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
